// File: rtl/lsq_pkg.sv
// rtl/lsq_pkg.sv - shared types and default widths for the load/store queue
package lsq_pkg;
  localparam int LSQ_DEPTH  = 16;
  localparam int PC_WIDTH   = 12;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int TAG_WIDTH  = 6;

  typedef enum logic [1:0] {IDLE, LD_WAIT, DRAIN} lsq_state_e;

  typedef struct packed {
    logic                  valid;
    logic                  is_load;
    logic [PC_WIDTH-1:0]   pc;
    logic [TAG_WIDTH-1:0]  rob_tag;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  addr_v;
    logic [DATA_WIDTH-1:0] data;
    logic                  data_v;
  } lsq_entry_t;
endpackage

// File: rtl/load_store_queue_if.sv
// rtl/load_store_queue_if.sv - dispatch/execute/memory/writeback bundle of the load/store queue
interface load_store_queue_if
  import lsq_pkg::*;
#(
  parameter int NUM_ENTRIES = LSQ_DEPTH
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);

  logic                  alloc_valid;
  logic                  alloc_is_load;
  logic [PC_WIDTH-1:0]   alloc_pc;
  logic [TAG_WIDTH-1:0]  alloc_rob_tag;
  logic                  alloc_ready;
  logic [IDX_W-1:0]      alloc_idx;
  logic                  upd_valid;
  logic [IDX_W-1:0]      upd_idx;
  logic [ADDR_WIDTH-1:0] upd_addr;
  logic [DATA_WIDTH-1:0] upd_data;
  logic                  st_commit;
  logic                  flush;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_we;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0] mem_req_wdata;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_resp_data;
  logic                  ld_wb_valid;
  logic [TAG_WIDTH-1:0]  ld_wb_tag;
  logic [DATA_WIDTH-1:0] ld_wb_data;
  logic [IDX_W:0]        count;

  modport slave (
    input  alloc_valid, alloc_is_load, alloc_pc, alloc_rob_tag,
    input  upd_valid, upd_idx, upd_addr, upd_data, st_commit, flush,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output alloc_ready, alloc_idx, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output ld_wb_valid, ld_wb_tag, ld_wb_data, count
  );

  modport master (
    output alloc_valid, alloc_is_load, alloc_pc, alloc_rob_tag,
    output upd_valid, upd_idx, upd_addr, upd_data, st_commit, flush,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  alloc_ready, alloc_idx, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  ld_wb_valid, ld_wb_tag, ld_wb_data, count
  );
endinterface

// File: rtl/lsq_ptr_ctrl.sv
// rtl/lsq_ptr_ctrl.sv - head/tail pointers with an extra wrap bit, occupancy and full/empty
module lsq_ptr_ctrl #(
  parameter int NUM_ENTRIES = 16,
  localparam int IDX_W = $clog2(NUM_ENTRIES)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush_i,
  input  logic           push_i,
  input  logic           pop_i,
  output logic [IDX_W:0] head_o,
  output logic [IDX_W:0] tail_o,
  output logic [IDX_W:0] count_o,
  output logic           full_o,
  output logic           empty_o
);
  logic [IDX_W:0] head_q, head_d, tail_q, tail_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (pop_i)  head_d = head_q + (IDX_W+1)'(1);
      if (push_i) tail_d = tail_q + (IDX_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Same slot index but opposite lap bit means the tail has lapped the head.
  assign full_o  = (head_q[IDX_W] != tail_q[IDX_W]) && (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]);
  assign empty_o = (head_q == tail_q);
  assign count_o = tail_q - head_q;
  assign head_o  = head_q;
  assign tail_o  = tail_q;
endmodule

// File: rtl/load_store_queue.sv
// rtl/load_store_queue.sv - in-order circular load/store queue; head entry accesses memory,
// stores only after ROB commit, loads write back one cycle after the response
module load_store_queue
  import lsq_pkg::*;
#(
  parameter int NUM_ENTRIES = LSQ_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  load_store_queue_if.slave lsq
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);

  lsq_entry_t            entries_q [NUM_ENTRIES];
  lsq_entry_t            entries_d [NUM_ENTRIES];
  lsq_state_e            state_q, state_d;
  logic                  ld_wb_valid_q, ld_wb_valid_d;
  logic [TAG_WIDTH-1:0]  ld_wb_tag_q, ld_wb_tag_d;
  logic [DATA_WIDTH-1:0] ld_wb_data_q, ld_wb_data_d;

  logic [IDX_W:0]   head, tail, count;
  logic             full, empty, push, pop, issue, fire;
  logic [IDX_W-1:0] head_idx, tail_idx;
  lsq_entry_t       head_e;
  logic [PC_WIDTH-1:0] head_pc_unused;

  lsq_ptr_ctrl #(.NUM_ENTRIES(NUM_ENTRIES)) u_ptr (
    .clk     (clk),
    .rst     (rst),
    .flush_i (lsq.flush),
    .push_i  (push),
    .pop_i   (pop),
    .head_o  (head),
    .tail_o  (tail),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign head_idx       = head[IDX_W-1:0];
  assign tail_idx       = tail[IDX_W-1:0];
  assign head_e         = entries_q[head_idx];
  assign head_pc_unused = head_e.pc;

  assign lsq.alloc_ready = !full;
  assign lsq.alloc_idx   = tail_idx;
  assign lsq.count       = count;
  assign push            = lsq.alloc_valid && !full && !lsq.flush;

  // A store fired in a flush cycle still goes out: it was already committed.
  assign issue = (state_q == IDLE) && !empty && head_e.valid && head_e.addr_v &&
                 (head_e.is_load || (head_e.data_v && lsq.st_commit));
  assign fire  = issue && lsq.mem_req_ready;

  assign lsq.mem_req_valid = issue;
  assign lsq.mem_req_we    = !head_e.is_load;
  assign lsq.mem_req_addr  = head_e.addr;
  assign lsq.mem_req_wdata = head_e.data;

  assign lsq.ld_wb_valid = ld_wb_valid_q;
  assign lsq.ld_wb_tag   = ld_wb_tag_q;
  assign lsq.ld_wb_data  = ld_wb_data_q;

  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    ld_wb_valid_d = 1'b0;
    ld_wb_tag_d   = ld_wb_tag_q;
    ld_wb_data_d  = ld_wb_data_q;
    case (state_q)
      IDLE: begin
        if (fire) begin
          if (head_e.is_load) state_d = lsq.flush ? DRAIN : LD_WAIT;
          else                pop     = 1'b1;
        end
      end
      LD_WAIT: begin
        if (lsq.mem_resp_valid) begin
          state_d = IDLE;
          if (!lsq.flush) begin
            pop           = 1'b1;
            ld_wb_valid_d = 1'b1;
            ld_wb_tag_d   = head_e.rob_tag;
            ld_wb_data_d  = lsq.mem_resp_data;
          end
        end else if (lsq.flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (lsq.mem_resp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    entries_d = entries_q;
    if (lsq.flush) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entries_d[i].valid  = 1'b0;
        entries_d[i].addr_v = 1'b0;
        entries_d[i].data_v = 1'b0;
      end
    end else begin
      if (lsq.upd_valid && entries_q[lsq.upd_idx].valid) begin
        entries_d[lsq.upd_idx].addr   = lsq.upd_addr;
        entries_d[lsq.upd_idx].addr_v = 1'b1;
        if (!entries_q[lsq.upd_idx].is_load) begin
          entries_d[lsq.upd_idx].data   = lsq.upd_data;
          entries_d[lsq.upd_idx].data_v = 1'b1;
        end
      end
      if (pop) begin
        entries_d[head_idx].valid  = 1'b0;
        entries_d[head_idx].addr_v = 1'b0;
        entries_d[head_idx].data_v = 1'b0;
      end
      if (push) begin
        entries_d[tail_idx] = '{valid: 1'b1, is_load: lsq.alloc_is_load, pc: lsq.alloc_pc,
                                rob_tag: lsq.alloc_rob_tag, addr: '0, addr_v: 1'b0,
                                data: '0, data_v: 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) entries_q[i] <= '0;
      state_q       <= IDLE;
      ld_wb_valid_q <= 1'b0;
      ld_wb_tag_q   <= '0;
      ld_wb_data_q  <= '0;
    end else begin
      entries_q     <= entries_d;
      state_q       <= state_d;
      ld_wb_valid_q <= ld_wb_valid_d;
      ld_wb_tag_q   <= ld_wb_tag_d;
      ld_wb_data_q  <= ld_wb_data_d;
    end
  end
endmodule
